// File: rtl/intc_pkg.sv
// -----------------------------------------------------------------------------
// intc_pkg
// Shared definitions for the intr_ctrl_prio interrupt controller:
//   - FSM state encodings (RESET, IDLE, REQ, SEND, WAIT_DONE) and the state_t
//     enum built on them
//   - default control codes sent to / expected from the processor
// -----------------------------------------------------------------------------
package intc_pkg;

    localparam logic [2:0] RESET     = 3'd0;
    localparam logic [2:0] IDLE      = 3'd1;
    localparam logic [2:0] REQ       = 3'd2;
    localparam logic [2:0] SEND      = 3'd3;
    localparam logic [2:0] WAIT_DONE = 3'd4;

    typedef enum logic [2:0] {
        ST_RESET     = RESET,
        ST_IDLE      = IDLE,
        ST_REQ       = REQ,
        ST_SEND      = SEND,
        ST_WAIT_DONE = WAIT_DONE
    } state_t;

    // Upper bus field sent with the winning ID / expected back on ISR done.
    localparam logic [4:0] CODE_TX_DEF   = 5'b01011;
    localparam logic [4:0] CODE_DONE_DEF = 5'b10100;

endpackage

// File: rtl/intr_ctrl_prio_if.sv
// -----------------------------------------------------------------------------
// intr_ctrl_prio_if
// Groups the request-side and processor-handshake signals of intr_ctrl_prio.
// The shared tri-state intr_bus is kept as a plain inout port on the
// controller so its resolution stays on an ordinary net.
//
// Handshake semantics: the controller raises intr_out; the processor answers
// each phase with a falling edge on the active-low intr_in (holding it low
// counts once). Phase 1 ack: controller drives {CODE_TX,id} on intr_bus.
// Phase 2 ack: controller releases the bus. Phase 3 ack: controller samples
// {CODE_DONE,id} from the processor on intr_bus.
//
// Signals:
//   intr_rq   [N_SRC]  level request per source       (to controller)
//   intr_mask [N_SRC]  1 = source masked               (to controller)
//   prio_mode          0 = fixed, 1 = round-robin      (to controller)
//   intr_in            processor ack, active-low       (to controller)
//   intr_out           interrupt request to processor  (from controller)
//   bus_oe             controller drives intr_bus      (from controller)
//   intr_id   [ID_W]   ID being serviced               (from controller)
//   busy               not in RESET/IDLE               (from controller)
//   err                one-cycle error pulse           (from controller)
//   state_dbg [3]      current FSM state               (from controller)
// -----------------------------------------------------------------------------
interface intr_ctrl_prio_if #(
    parameter int N_SRC = 8,
    parameter int ID_W  = $clog2(N_SRC)
);

    logic [N_SRC-1:0] intr_rq;
    logic [N_SRC-1:0] intr_mask;
    logic             prio_mode;
    logic             intr_in;
    logic             intr_out;
    logic             bus_oe;
    logic [ID_W-1:0]  intr_id;
    logic             busy;
    logic             err;
    logic [2:0]       state_dbg;

    // Controller side.
    modport slave (
        input  intr_rq, intr_mask, prio_mode, intr_in,
        output intr_out, bus_oe, intr_id, busy, err, state_dbg
    );

    // Peripheral/processor side.
    modport master (
        output intr_rq, intr_mask, prio_mode, intr_in,
        input  intr_out, bus_oe, intr_id, busy, err, state_dbg
    );

endinterface

// File: rtl/intc_prio_arbiter.sv
// -----------------------------------------------------------------------------
// intc_prio_arbiter
// Combinational single-cycle priority pick over N_SRC eligible lines.
//   i_eligible [N_SRC]  requesting and unmasked sources
//   i_start    [ID_W]   round-robin search start index
//   i_mode              0 = fixed (index 0 highest), 1 = round-robin
//   o_winner   [ID_W]   selected source index
//   o_valid             at least one source eligible
// Fixed mode is round-robin search anchored at index 0, so both modes share
// one search loop.
// -----------------------------------------------------------------------------
module intc_prio_arbiter #(
    parameter int N_SRC = 8,
    parameter int ID_W  = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] i_eligible,
    input  logic [ID_W-1:0]  i_start,
    input  logic             i_mode,
    output logic [ID_W-1:0]  o_winner,
    output logic             o_valid
);

    int w_start;
    int w_idx;

    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        w_idx    = 0;
        // An out-of-range start (non-power-of-two N_SRC) falls back to 0.
        w_start  = (i_mode && (int'(i_start) < N_SRC)) ? int'(i_start) : 0;
        // Walk from the farthest offset down so the nearest hit wins last.
        for (int k = N_SRC - 1; k >= 0; k--) begin
            w_idx = w_start + k;
            if (w_idx >= N_SRC) begin
                w_idx = w_idx - N_SRC;
            end
            if (i_eligible[ID_W'(w_idx)]) begin
                o_winner = ID_W'(w_idx);
                o_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intr_ctrl_prio.sv
// -----------------------------------------------------------------------------
// intr_ctrl_prio
// Parametrised interrupt controller: arbitrates N_SRC maskable level requests
// (fixed or round-robin priority) and runs the intr_out / intr_in / shared-bus
// handshake that delivers the winning ID and collects the ISR-done word.
//
// Ports:
//   clk       clock, rising edge
//   reset     asynchronous, active-high
//   ifc       intr_ctrl_prio_if.slave (requests, masks, mode, handshake, status)
//   intr_bus  [BUS_W] shared tri-state bus, driven only while bus_oe=1
//
// Optional feature macro: INTC_ACK_TIMEOUT_EN
//   Defined: an acknowledge timeout of TIMEOUT_CYC cycles in REQ, SEND and
//   WAIT_DONE pulses err and returns to RESET.
//   Undefined: the controller waits indefinitely for each ack.
// -----------------------------------------------------------------------------
module intr_ctrl_prio
    import intc_pkg::*;
#(
    parameter int                     N_SRC       = 8,
    parameter int                     ID_W        = $clog2(N_SRC),
    parameter int                     BUS_W       = 8,
    parameter logic [BUS_W-ID_W-1:0]  CODE_TX     = CODE_TX_DEF,
    parameter logic [BUS_W-ID_W-1:0]  CODE_DONE   = CODE_DONE_DEF,
    parameter int                     TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    intr_ctrl_prio_if.slave   ifc,
    inout  wire  [BUS_W-1:0]  intr_bus
);

    if (N_SRC < 2 || N_SRC > 64 || BUS_W <= ID_W || TIMEOUT_CYC < 1) begin : g_param_check
        $error("intr_ctrl_prio: illegal parameter combination");
    end

    state_t            r_state;
    logic              r_in_q;
    logic              r_intr_out;
    logic              r_bus_oe;
    logic [BUS_W-1:0]  r_bus_reg;
    logic [ID_W-1:0]   r_id;
    logic [ID_W-1:0]   r_rr_ptr;
    logic              r_err;

    logic [N_SRC-1:0]  w_eligible;
    logic [ID_W-1:0]   w_winner;
    logic              w_win_valid;
    logic              w_ack;
    logic              w_done_match;
    logic [ID_W-1:0]   w_rr_next;
    logic              w_to_hit;

    // A held-low intr_in yields a single ack because r_in_q follows it low.
    assign w_ack        = r_in_q & ~ifc.intr_in;
    assign w_eligible   = ifc.intr_rq & ~ifc.intr_mask;
    // X/Z on the bus makes the equality unknown, which is treated as mismatch.
    assign w_done_match = (intr_bus == {CODE_DONE, r_id});
    assign w_rr_next    = (r_id == ID_W'(N_SRC - 1)) ? '0 : r_id + 1'b1;

    intc_prio_arbiter #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_arb (
        .i_eligible (w_eligible),
        .i_start    (r_rr_ptr),
        .i_mode     (ifc.prio_mode),
        .o_winner   (w_winner),
        .o_valid    (w_win_valid)
    );

`ifdef INTC_ACK_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [TO_W-1:0] r_to_cnt;
    logic            w_in_service;

    assign w_in_service = (r_state == ST_REQ) || (r_state == ST_SEND) ||
                          (r_state == ST_WAIT_DONE);
    // Outside a service phase the counter sits at 0, so every entry into
    // REQ/SEND/WAIT_DONE starts from 0; acks restart it too.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_to_cnt <= '0;
        end else if (!w_in_service || w_ack) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Fires on the edge where the count would reach TIMEOUT_CYC.
    assign w_to_hit = w_in_service && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
    assign w_to_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_RESET;
            r_in_q     <= 1'b1;
            r_intr_out <= 1'b0;
            r_bus_oe   <= 1'b0;
            r_bus_reg  <= '0;
            r_id       <= '0;
            r_rr_ptr   <= '0;
            r_err      <= 1'b0;
        end else begin
            r_in_q <= ifc.intr_in;
            r_err  <= 1'b0;
            case (r_state)
                ST_RESET: begin
                    r_intr_out <= 1'b0;
                    r_bus_oe   <= 1'b0;
                    r_id       <= '0;
                    r_rr_ptr   <= '0;
                    r_state    <= ST_IDLE;
                end
                ST_IDLE: begin
                    // The winner is latched; later request/mask changes do
                    // not abort this service.
                    if (w_win_valid) begin
                        r_id       <= w_winner;
                        r_intr_out <= 1'b1;
                        r_state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (w_ack) begin
                        r_intr_out <= 1'b0;
                        r_bus_reg  <= {CODE_TX, r_id};
                        r_bus_oe   <= 1'b1;
                        r_state    <= ST_SEND;
                    end else if (w_to_hit) begin
                        r_err      <= 1'b1;
                        r_intr_out <= 1'b0;
                        r_bus_oe   <= 1'b0;
                        r_state    <= ST_RESET;
                    end
                end
                ST_SEND: begin
                    if (w_ack) begin
                        r_bus_oe <= 1'b0;
                        r_state  <= ST_WAIT_DONE;
                    end else if (w_to_hit) begin
                        r_err      <= 1'b1;
                        r_intr_out <= 1'b0;
                        r_bus_oe   <= 1'b0;
                        r_state    <= ST_RESET;
                    end
                end
                ST_WAIT_DONE: begin
                    if (w_ack) begin
                        if (w_done_match) begin
                            r_rr_ptr <= w_rr_next;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= ST_RESET;
                        end
                    end else if (w_to_hit) begin
                        r_err      <= 1'b1;
                        r_intr_out <= 1'b0;
                        r_bus_oe   <= 1'b0;
                        r_state    <= ST_RESET;
                    end
                end
                default: begin
                    // Illegal encoding: release the bus and restart.
                    r_bus_oe   <= 1'b0;
                    r_intr_out <= 1'b0;
                    r_state    <= ST_RESET;
                end
            endcase
        end
    end

    assign intr_bus      = r_bus_oe ? r_bus_reg : {BUS_W{1'bz}};
    assign ifc.intr_out  = r_intr_out;
    assign ifc.bus_oe    = r_bus_oe;
    assign ifc.intr_id   = r_id;
    assign ifc.err       = r_err;
    assign ifc.busy      = (r_state != ST_RESET) && (r_state != ST_IDLE);
    assign ifc.state_dbg = r_state;

endmodule

// File: tb/tb_intr_ctrl_prio.sv
// -----------------------------------------------------------------------------
// tb_intr_ctrl_prio
// Directed bench for intr_ctrl_prio (N_SRC=8, BUS_W=8). Inputs change 2 ns
// after a rising edge; outputs are sampled at the same point. Expected IDs are
// queued when a request is driven and popped when intr_out rises.
// -----------------------------------------------------------------------------
module tb_intr_ctrl_prio;
    import intc_pkg::*;

    localparam int N   = 8;
    localparam int IDW = 3;
    localparam int BW  = 8;
`ifdef INTC_ACK_TIMEOUT_EN
    localparam int TO  = 10;
`else
    localparam int TO  = 255;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    intr_ctrl_prio_if #(.N_SRC(N), .ID_W(IDW)) ifc ();

    wire  [BW-1:0] intr_bus;
    logic          tb_oe;
    logic [BW-1:0] tb_val;
    assign intr_bus = tb_oe ? tb_val : {BW{1'bz}};

    intr_ctrl_prio #(
        .N_SRC       (N),
        .ID_W        (IDW),
        .BUS_W       (BW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ifc      (ifc),
        .intr_bus (intr_bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    logic [IDW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // One falling edge on intr_in; returns just after the detecting edge.
    task automatic ack();
        ifc.intr_in = 1'b0;
        step();
        ifc.intr_in = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic wait_and_check_id(input string tag);
        logic [IDW-1:0] e;
        int n;
        n = 0;
        while (ifc.intr_out !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check({tag, " intr_out rises"}, 32'(ifc.intr_out), 32'd1);
        check({tag, " queue has entry"}, 32'(exp_q.size() > 0), 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check({tag, " intr_id"}, 32'(ifc.intr_id), 32'(e));
        check({tag, " busy"}, 32'(ifc.busy), 32'd1);
    endtask

    task automatic finish_service(input string tag, input logic [BW-1:0] done_word,
                                  input logic [BW-1:0] exp_tx);
        ack();
        check({tag, " intr_out after ack1"}, 32'(ifc.intr_out), 32'd0);
        check({tag, " bus_oe after ack1"}, 32'(ifc.bus_oe), 32'd1);
        check({tag, " bus word"}, 32'(intr_bus), 32'(exp_tx));
        step();
        ack();
        check({tag, " bus_oe after ack2"}, 32'(ifc.bus_oe), 32'd0);
        check({tag, " state after ack2"}, 32'(ifc.state_dbg), 32'(WAIT_DONE));
        step();
        tb_val = done_word;
        tb_oe  = 1'b1;
        ack();
        tb_oe  = 1'b0;
    endtask

    task automatic serve_ok(input string tag, input logic [IDW-1:0] id);
        wait_and_check_id(tag);
        finish_service(tag, {CODE_DONE_DEF, id}, {CODE_TX_DEF, id});
        check({tag, " back to IDLE"}, 32'(ifc.state_dbg), 32'(IDLE));
        check({tag, " no err"}, 32'(ifc.err), 32'd0);
        check({tag, " intr_out gap"}, 32'(ifc.intr_out), 32'd0);
    endtask

    initial begin
        reset         = 1'b1;
        ifc.intr_rq   = '0;
        ifc.intr_mask = '0;
        ifc.prio_mode = 1'b0;
        ifc.intr_in   = 1'b1;
        tb_oe         = 1'b0;
        tb_val        = '0;

        // Reset values.
        step();
        step();
        check("rst intr_out", 32'(ifc.intr_out), 32'd0);
        check("rst bus_oe", 32'(ifc.bus_oe), 32'd0);
        check("rst intr_id", 32'(ifc.intr_id), 32'd0);
        check("rst busy", 32'(ifc.busy), 32'd0);
        check("rst err", 32'(ifc.err), 32'd0);
        check("rst state", 32'(ifc.state_dbg), 32'(RESET));

        // Fixed priority: lowest eligible of 1010_0000 is 5; 2 cycles from release.
        ifc.intr_rq = 8'b1010_0000;
        exp_q.push_back(3'd5);
        reset = 1'b0;
        step();
        check("fix RESET lasts 1 cycle", 32'(ifc.intr_out), 32'd0);
        check("fix state IDLE", 32'(ifc.state_dbg), 32'(IDLE));
        step();
        check("fix intr_out latency", 32'(ifc.intr_out), 32'd1);
        wait_and_check_id("fix");
        ifc.intr_rq = '0;
        finish_service("fix", 8'b10100_101, 8'b01011_101);
        check("fix back to IDLE", 32'(ifc.state_dbg), 32'(IDLE));
        check("fix no err", 32'(ifc.err), 32'd0);
        step();
        check("fix stays idle", 32'(ifc.intr_out), 32'd0);

        // Round-robin over all-ones requests, then fixed mode.
        do_reset();
        ifc.prio_mode = 1'b1;
        ifc.intr_rq   = 8'hFF;
        for (int i = 0; i < 5; i++) exp_q.push_back(IDW'(i));
        for (int i = 0; i < 5; i++) serve_ok("rr", IDW'(i));
        ifc.prio_mode = 1'b0;
        for (int i = 0; i < 3; i++) exp_q.push_back(3'd0);
        for (int i = 0; i < 3; i++) serve_ok("fixed rep", 3'd0);
        ifc.intr_rq = '0;
        step();

        // Masking: 0x0C with bit 2 masked wins 3; remasking mid-REQ keeps 3.
        ifc.intr_rq   = 8'h0C;
        ifc.intr_mask = 8'h04;
        exp_q.push_back(3'd3);
        wait_and_check_id("mask");
        ifc.intr_mask = 8'h08;
        step();
        step();
        check("mask held intr_out", 32'(ifc.intr_out), 32'd1);
        check("mask held id", 32'(ifc.intr_id), 32'd3);
        ifc.intr_rq = '0;
        finish_service("mask", {CODE_DONE_DEF, 3'd3}, {CODE_TX_DEF, 3'd3});
        check("mask back to IDLE", 32'(ifc.state_dbg), 32'(IDLE));
        check("mask no err", 32'(ifc.err), 32'd0);
        ifc.intr_mask = '0;

        // Bad DONE: ID field mismatch while serving 5.
        ifc.intr_rq = 8'b1010_0000;
        exp_q.push_back(3'd5);
        wait_and_check_id("bad");
        ifc.intr_rq = '0;
        finish_service("bad", 8'b10100_110, 8'b01011_101);
        check("bad err pulse", 32'(ifc.err), 32'd1);
        check("bad bus_oe", 32'(ifc.bus_oe), 32'd0);
        check("bad state RESET", 32'(ifc.state_dbg), 32'(RESET));
        step();
        check("bad err one cycle", 32'(ifc.err), 32'd0);
        check("bad state IDLE", 32'(ifc.state_dbg), 32'(IDLE));

        // Reset mid-SEND; afterwards round-robin must restart from 0, not 7.
        ifc.prio_mode = 1'b1;
        ifc.intr_rq   = 8'h40;
        exp_q.push_back(3'd6);
        exp_q.push_back(3'd6);
        serve_ok("rst pre", 3'd6);
        wait_and_check_id("rst mid");
        ack();
        check("rst mid bus_oe", 32'(ifc.bus_oe), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("rst async bus_oe", 32'(ifc.bus_oe), 32'd0);
        check("rst async intr_out", 32'(ifc.intr_out), 32'd0);
        check("rst async state", 32'(ifc.state_dbg), 32'(RESET));
        step();
        ifc.intr_rq = 8'hFF;
        exp_q.push_back(3'd0);
        reset = 1'b0;
        wait_and_check_id("rst rr_ptr");
        ifc.intr_rq = '0;
        finish_service("rst rr", {CODE_DONE_DEF, 3'd0}, {CODE_TX_DEF, 3'd0});
        check("rst rr back to IDLE", 32'(ifc.state_dbg), 32'(IDLE));

`ifdef INTC_ACK_TIMEOUT_EN
        // No ack after intr_out rises: err expected 10 cycles later.
        begin
            int n;
            ifc.prio_mode = 1'b0;
            ifc.intr_rq   = 8'h01;
            exp_q.push_back(3'd0);
            wait_and_check_id("to");
            ifc.intr_rq = '0;
            n = 0;
            while (ifc.err !== 1'b1 && n < 15) begin
                step();
                n++;
            end
            check("to err delay", 32'(n), 32'd10);
            check("to intr_out", 32'(ifc.intr_out), 32'd0);
            check("to bus_oe", 32'(ifc.bus_oe), 32'd0);
        end
`endif

        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/intr_ctrl_prio.md
# intr_ctrl_prio

Parametrised interrupt controller, successor to the 8-source polling controller. It arbitrates N_SRC maskable level-sensitive request lines in one cycle, using either fixed or round-robin priority. It then runs the intr_out / intr_in / shared-bus handshake to deliver the winning source ID to the processor and to collect its ISR-done acknowledgement. It sits between the peripheral request lines and the processor interrupt pins.

## Interface
- N_SRC, 8: number of request sources, 2..64
- ID_W, $clog2(N_SRC): source ID field width
- BUS_W, 8: intr_bus width; must be greater than ID_W
- CODE_TX, 5'b01011: width BUS_W-ID_W; control code sent with the ID
- CODE_DONE, 5'b10100: width BUS_W-ID_W; control code expected from the processor on ISR completion
- TIMEOUT_CYC, 255: acknowledge timeout in cycles; used only with INTC_ACK_TIMEOUT_EN
- clk  in  1  clock; everything except reset is synchronous to the rising edge
- reset  in  1  asynchronous, active-high
- intr_rq  in  N_SRC  level request per source
- intr_mask  in  N_SRC  1 = source masked
- prio_mode  in  1  0 = fixed priority (index 0 highest), 1 = round-robin; sampled only in IDLE
- intr_in  in  1  processor acknowledge, active-low; an ack is a falling edge
- intr_out  out  1  interrupt request to the processor
- intr_bus  inout  BUS_W  shared bus; driven only while bus_oe=1, otherwise Z
- bus_oe  out  1  controller is driving intr_bus
- intr_id  out  ID_W  ID currently being serviced
- busy  out  1  high in every state except RESET and IDLE
- err  out  1  one-cycle error pulse

## Operation
- Ack detection: intr_in is registered as in_q, reset value 1. ack = in_q & ~intr_in. A processor holding intr_in low counts as a single ack.
- eligible = intr_rq & ~intr_mask.
- Fixed mode: the winner is the lowest eligible index.
- Round-robin mode: the search starts at rr_ptr, increments and wraps N_SRC-1 to 0, and takes the first eligible index found.
- FSM:
  - RESET: clear intr_out, bus_oe, id, rr_ptr=0. Go to IDLE next cycle.
  - IDLE: if eligible is nonzero, latch the winner into id, set intr_out=1, go to REQ.
  - REQ: on ack, set intr_out=0, load bus_reg={CODE_TX,id}, set bus_oe=1, go to SEND.
  - SEND: on ack, set bus_oe=0, go to WAIT_DONE.
  - WAIT_DONE: on ack, sample intr_bus.
    - Sample equals {CODE_DONE,id}: set rr_ptr=id+1 (wrapping at N_SRC), go to IDLE.
    - Code or ID mismatch (either one): pulse err, go to RESET.
- The service is latched. Deasserting or masking the serviced source after IDLE does not abort the handshake.
- Non-power-of-two N_SRC: IDs at or above N_SRC never win.
- Illegal state encoding goes to RESET with bus_oe=0.

## Timing
- Reset values: intr_out=0, bus_oe=0, intr_bus=Z, intr_id=0, busy=0, err=0.
- Reset asserted mid-handshake drops bus_oe and intr_out immediately (asynchronous) and returns to RESET.
- Request to intr_out: a request present in IDLE at edge k gives intr_out=1 after edge k.
- Minimum reset-release to intr_out: 2 cycles, because RESET lasts one cycle.
- Ack to response: the output changes at the edge that detects the ack, i.e. 1 cycle after intr_in falls.
- Bus is driven from the edge after the first ack until the edge after the second ack.
- Back-to-back service: IDLE re-arbitrates on the cycle after the DONE ack. Minimum gap with intr_out low is 1 cycle.
- An ack in IDLE or RESET is ignored.

## Configuration
- INTC_ACK_TIMEOUT_EN defined:
  - An 8-bit-or-wider counter clears on entry to REQ, SEND and WAIT_DONE, and on every ack.
  - When it reaches TIMEOUT_CYC: pulse err, clear intr_out and bus_oe, go to RESET.
- Not defined: the controller waits indefinitely; err fires only on a bad DONE word.

## Structure
- Package intc_pkg holds:
  - state localparams RESET=0, IDLE=1, REQ=2, SEND=3, WAIT_DONE=4
  - default CODE_TX and CODE_DONE
- Sub-module intc_prio_arbiter: combinational.
  - Inputs: eligible, start index, mode.
  - Outputs: winner ID and valid.
  - Parametrised by N_SRC.

## Test plan
- Fixed priority, N_SRC=8: intr_rq=8'b1010_0000, mask=0. Expect intr_id=5 and intr_out high 1 cycle later. Then full handshake with bus 8'b10100_101; expect 8'b01011_101 on the bus between acks and return to IDLE.
- Round-robin: intr_rq=8'hFF held, five services. Expect IDs 0,1,2,3,4. With mode=0, expect ID 0 every time.
- Masking: intr_rq=8'h0C, mask=8'h04. Expect ID 3. Set mask=8'h08 mid-REQ; the service still completes as ID 3.
- Bad DONE: respond 8'b10100_110 while serving ID 5. Expect an err pulse, bus_oe=0, and a pass through RESET.
- Reset mid-SEND: assert reset with bus_oe=1. Expect bus Z and intr_out=0 immediately, and rr_ptr back to 0.
- With INTC_ACK_TIMEOUT_EN and TIMEOUT_CYC=10: no ack after intr_out rises. Expect err 10 cycles later and intr_out low.
